ps2_direction_rx: RTL and testbench

- PS/2 device-to-host receiver for the snake game keyboard input.
- Samples the board ps2_clk/ps2_data lines and deframes 11-bit PS/2 frames into scan codes.
- Absorbs the E0 (extended) and F0 (break) prefixes.
- Maps arrow keys and WASD make-codes to a 2-bit direction, which the game CPU reads while the VGA controller draws the snake.
- Input-only. This block never drives the PS/2 lines; the top level keeps them inout with pull-ups.

---
 rtl/ps2_direction_rx.sv | 248 ++++++++++++++++++++++++
 tb/tb_ps2_direction_rx.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_direction_rx.sv
// PS/2 device-to-host receiver for the snake game keyboard.
// Synchronizes and deglitches the pad lines, deframes 11-bit PS/2 frames,
// absorbs E0/F0 prefixes and maps arrow/WASD make codes to a direction.
// Optional frame watchdog: define PS2_WATCHDOG_EN.
//
// Ports:
//   clk          system clock (100 MHz)
//   reset        asynchronous active-high reset
//   ps2_clk      raw PS/2 clock from the pad
//   ps2_data     raw PS/2 data from the pad
//   scan_code    last final code (prefixes excluded)
//   scan_valid   1-cycle pulse when scan_code and flags update
//   is_extended  E0 preceded the current scan_code
//   is_break     F0 preceded the current scan_code
//   frame_err    1-cycle pulse on parity, stop-bit or timeout error
//   direction    00 up, 01 right, 10 down, 11 left
//   dir_valid    1-cycle pulse when direction is written
module ps2_direction_rx #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       is_extended,
    output logic       is_break,
    output logic       frame_err,
    output logic [1:0] direction,
    output logic       dir_valid
);

    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    if (SYNC_STAGES < 2 || FILTER_LEN < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("ps2_direction_rx: parameter out of range");
    end

    // Input synchronizers; idle PS/2 lines are high.
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // Glitch filter: counts consecutive samples that disagree with the filtered clock.
    logic              clk_filt;
    logic [FCNT_W-1:0] filt_cnt;
    logic              fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s;
                filt_cnt <= '0;
                fall     <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + FCNT_W'(1);
            end
        end
    end

    // {hit, direction} for a final code with its extended flag.
    function automatic logic [2:0] map_dir(input logic ext, input logic [7:0] code);
        logic [2:0] r;
        r = 3'b000;
        if (ext) begin
            case (code)
                8'h75:   r = 3'b100;
                8'h74:   r = 3'b101;
                8'h72:   r = 3'b110;
                8'h6B:   r = 3'b111;
                default: r = 3'b000;
            endcase
        end else begin
            case (code)
                8'h1D:   r = 3'b100;
                8'h23:   r = 3'b101;
                8'h1B:   r = 3'b110;
                8'h1C:   r = 3'b111;
                default: r = 3'b000;
            endcase
        end
        return r;
    endfunction

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       parity_ok, parity_ok_n;
    logic       ext_flag, ext_n;
    logic       brk_flag, brk_n;
    logic [7:0] scan_code_n;
    logic       scan_valid_n, is_ext_n, is_brk_n, frame_err_n, dir_valid_n;
    logic [1:0] direction_n;
    logic [2:0] hit_dir;
    logic       wd_expire;

`ifdef PS2_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (state != S_IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Frame watchdog: measures the gap since the last filtered edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == S_IDLE || fall || wd_expire) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            parity_ok   <= 1'b0;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            scan_code   <= 8'h00;
            scan_valid  <= 1'b0;
            is_extended <= 1'b0;
            is_break    <= 1'b0;
            frame_err   <= 1'b0;
            direction   <= 2'b01;
            dir_valid   <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            parity_ok   <= parity_ok_n;
            ext_flag    <= ext_n;
            brk_flag    <= brk_n;
            scan_code   <= scan_code_n;
            scan_valid  <= scan_valid_n;
            is_extended <= is_ext_n;
            is_break    <= is_brk_n;
            frame_err   <= frame_err_n;
            direction   <= direction_n;
            dir_valid   <= dir_valid_n;
        end
    end

    // Deframing, prefix absorption and direction mapping.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        parity_ok_n  = parity_ok;
        ext_n        = ext_flag;
        brk_n        = brk_flag;
        scan_code_n  = scan_code;
        is_ext_n     = is_extended;
        is_brk_n     = is_break;
        direction_n  = direction;
        scan_valid_n = 1'b0;
        dir_valid_n  = 1'b0;
        frame_err_n  = 1'b0;
        hit_dir      = map_dir(ext_flag, shift);

        if (wd_expire) begin
            state_n     = S_IDLE;
            ext_n       = 1'b0;
            brk_n       = 1'b0;
            frame_err_n = 1'b1;
        end else if (fall) begin
            case (state)
                S_IDLE: begin
                    // A high data line here is a stray edge, not a start bit.
                    if (!data_s) begin
                        state_n   = S_DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_n   = {data_s, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_ok_n = ^{shift, data_s};
                    state_n     = S_STOP;
                end
                S_STOP: begin
                    state_n = S_IDLE;
                    if (data_s && parity_ok) begin
                        if (shift == 8'hE0) begin
                            ext_n = 1'b1;
                        end else if (shift == 8'hF0) begin
                            brk_n = 1'b1;
                        end else begin
                            scan_code_n  = shift;
                            is_ext_n     = ext_flag;
                            is_brk_n     = brk_flag;
                            scan_valid_n = 1'b1;
                            ext_n        = 1'b0;
                            brk_n        = 1'b0;
                            if (!brk_flag && hit_dir[2]) begin
                                direction_n = hit_dir[1:0];
                                dir_valid_n = 1'b1;
                            end
                        end
                    end else begin
                        frame_err_n = 1'b1;
                        ext_n       = 1'b0;
                        brk_n       = 1'b0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_direction_rx.sv
// Self-checking bench for ps2_direction_rx: directed scenarios plus a
// randomized frame stream checked against a frame-level reference model.
module tb_ps2_direction_rx;

    localparam int unsigned TO_CYC = 5000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid, is_extended, is_break, frame_err, dir_valid;
    logic [1:0] direction;

    always #5 clk = ~clk;

    ps2_direction_rx #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .is_extended(is_extended),
        .is_break   (is_break),
        .frame_err  (frame_err),
        .direction  (direction),
        .dir_valid  (dir_valid)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: running totals, pulse widths and capture times.
    int   sv_tot = 0, dv_tot = 0, fe_tot = 0, wide_tot = 0, dv_alone = 0;
    int   sv_cyc = 0, fe_cyc = 0;
    logic p_sv = 1'b0, p_dv = 1'b0, p_fe = 1'b0;

    always @(negedge clk) begin
        if (scan_valid === 1'b1) begin
            sv_tot++;
            sv_cyc = cyc;
        end
        if (dir_valid === 1'b1) begin
            dv_tot++;
            if (scan_valid !== 1'b1) dv_alone++;
        end
        if (frame_err === 1'b1) begin
            fe_tot++;
            fe_cyc = cyc;
        end
        if ((scan_valid === 1'b1 && p_sv) || (dir_valid === 1'b1 && p_dv) ||
            (frame_err === 1'b1 && p_fe)) wide_tot++;
        p_sv = (scan_valid === 1'b1);
        p_dv = (dir_valid === 1'b1);
        p_fe = (frame_err === 1'b1);
    end

    // Reference model at frame granularity.
    logic [7:0] ext_keys [4] = '{8'h75, 8'h74, 8'h72, 8'h6B};
    logic [7:0] norm_keys[4] = '{8'h1D, 8'h23, 8'h1B, 8'h1C};
    bit         m_ext, m_brk;
    logic [1:0] m_dir;
    logic [7:0] m_code;
    bit         exp_sv, exp_dv, exp_fe, exp_ext, exp_brk;

    function automatic int lookup(input bit ext, input logic [7:0] c);
        for (int i = 0; i < 4; i++) begin
            if ((ext ? ext_keys[i] : norm_keys[i]) == c) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ext  = 0;
        m_brk  = 0;
        m_dir  = 2'b01;
        m_code = 8'h00;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        int d;
        exp_sv = 0;
        exp_dv = 0;
        exp_fe = 0;
        if (!good) begin
            exp_fe = 1;
            m_ext  = 0;
            m_brk  = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            exp_sv  = 1;
            m_code  = b;
            exp_ext = m_ext;
            exp_brk = m_brk;
            if (!m_brk) begin
                d = lookup(m_ext, b);
                if (d >= 0) begin
                    m_dir  = 2'(d);
                    exp_dv = 1;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // PS/2 line driver: data changes mid-high, then the clock falls.
    int bit_per = 2000;
    int last_fall = 0;
    int d_sv, d_dv, d_fe, d_wide, d_alone;

    task automatic drive_bit(input logic v);
        @(negedge clk);
        ps2_data = v;
        repeat (bit_per / 4 - 1) @(negedge clk);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        repeat (bit_per / 2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (bit_per / 4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        int   s_sv, s_dv, s_fe, s_wide, s_alone;
        logic par;
        s_sv    = sv_tot;
        s_dv    = dv_tot;
        s_fe    = fe_tot;
        s_wide  = wide_tot;
        s_alone = dv_alone;
        par     = (~^b) ^ bad_par;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(1'b1);
        d_sv    = sv_tot - s_sv;
        d_dv    = dv_tot - s_dv;
        d_fe    = fe_tot - s_fe;
        d_wide  = wide_tot - s_wide;
        d_alone = dv_alone - s_alone;
        model_frame(b, !bad_par);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        checks++;
        if ({scan_code, scan_valid, is_extended, is_break, frame_err, direction, dir_valid}
            !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold: code=%h sv=%b ext=%b brk=%b fe=%b dir=%b dv=%b want 00/0/0/0/0/01/0",
                     scan_code, scan_valid, is_extended, is_break, frame_err, direction, dir_valid);
        end
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (sv_tot + dv_tot + fe_tot !== 0 || direction !== 2'b01) begin
            failures++;
            $display("FAIL reset_release: pulses=%0d dir=%b want 0 pulses dir=01",
                     sv_tot + dv_tot + fe_tot, direction);
        end
        model_reset();
    endtask

    task automatic test_make_code();
        send_frame(8'h1D, 1'b0);
        checks++;
        if (d_sv !== 1 || d_wide !== 0) begin
            failures++;
            $display("FAIL make_scan_pulse: pulses=%0d wide=%0d want 1/0", d_sv, d_wide);
        end
        checks++;
        if ({scan_code, is_extended, is_break} !== {8'h1D, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL make_code: code=%h ext=%b brk=%b want 1d/0/0", scan_code, is_extended, is_break);
        end
        checks++;
        if (direction !== 2'b00 || d_dv !== 1) begin
            failures++;
            $display("FAIL make_dir: dir=%b dv=%0d want 00/1", direction, d_dv);
        end
        checks++;
        if (sv_cyc - last_fall !== 11) begin
            failures++;
            $display("FAIL make_latency: got %0d want 11", sv_cyc - last_fall);
        end
        bit_per = 48;
    endtask

    task automatic test_extended();
        send_frame(8'hE0, 1'b0);
        checks++;
        if (d_sv !== 0 || d_fe !== 0) begin
            failures++;
            $display("FAIL ext_prefix_silent: sv=%0d fe=%0d want 0/0", d_sv, d_fe);
        end
        send_frame(8'h74, 1'b0);
        checks++;
        if ({scan_code, is_extended, is_break, direction} !== {8'h74, 1'b1, 1'b0, 2'b01} || d_dv !== 1) begin
            failures++;
            $display("FAIL ext_make: code=%h ext=%b brk=%b dir=%b dv=%0d want 74/1/0/01/1",
                     scan_code, is_extended, is_break, direction, d_dv);
        end
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h74, 1'b0);
        checks++;
        if ({is_extended, is_break, direction} !== {1'b1, 1'b1, 2'b01} || d_sv !== 1 || d_dv !== 0) begin
            failures++;
            $display("FAIL ext_break: ext=%b brk=%b dir=%b sv=%0d dv=%0d want 1/1/01/1/0",
                     is_extended, is_break, direction, d_sv, d_dv);
        end
    endtask

    task automatic test_parity_error();
        send_frame(8'h1C, 1'b1);
        checks++;
        if (d_fe !== 1 || d_sv !== 0 || d_wide !== 0 || direction !== 2'b01) begin
            failures++;
            $display("FAIL parity_err: fe=%0d sv=%0d wide=%0d dir=%b want 1/0/0/01", d_fe, d_sv, d_wide, direction);
        end
        checks++;
        if (fe_cyc - last_fall !== 11) begin
            failures++;
            $display("FAIL parity_latency: got %0d want 11", fe_cyc - last_fall);
        end
        send_frame(8'h1C, 1'b0);
        checks++;
        if (direction !== 2'b11 || d_dv !== 1) begin
            failures++;
            $display("FAIL parity_recover: dir=%b dv=%0d want 11/1", direction, d_dv);
        end
    endtask

    task automatic test_glitch();
        int s;
        s = sv_tot + dv_tot + fe_tot;
        @(negedge clk);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (sv_tot + dv_tot + fe_tot !== s) begin
            failures++;
            $display("FAIL glitch_quiet: pulses=%0d want 0", sv_tot + dv_tot + fe_tot - s);
        end
        send_frame(8'h1B, 1'b0);
        checks++;
        if (direction !== 2'b10 || scan_code !== 8'h1B || d_sv !== 1 || d_fe !== 0) begin
            failures++;
            $display("FAIL glitch_frame: dir=%b code=%h sv=%0d fe=%0d want 10/1b/1/0",
                     direction, scan_code, d_sv, d_fe);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int         s;
        b = 8'h75;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({scan_code, scan_valid, is_extended, is_break, frame_err, direction, dir_valid}
            !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL midframe_reset: code=%h sv=%b ext=%b brk=%b fe=%b dir=%b dv=%b want 00/0/0/0/0/01/0",
                     scan_code, scan_valid, is_extended, is_break, frame_err, direction, dir_valid);
        end
        repeat (5) @(negedge clk);
        s = sv_tot + dv_tot + fe_tot;
        reset    = 1'b0;
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        model_reset();
        send_frame(8'h1D, 1'b0);
        checks++;
        if (direction !== 2'b00 || d_sv !== 1 || d_dv !== 1 || d_fe !== 0 ||
            sv_tot + dv_tot + fe_tot - s !== 2) begin
            failures++;
            $display("FAIL midframe_recover: dir=%b sv=%0d dv=%0d fe=%0d total=%0d want 00/1/1/0/2",
                     direction, d_sv, d_dv, d_fe, sv_tot + dv_tot + fe_tot - s);
        end
    endtask

    task automatic test_watchdog();
        logic [7:0] b;
        int         s_fe, s_sv;
        b    = 8'h2A;
        s_fe = fe_tot;
        s_sv = sv_tot;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
`ifdef PS2_WATCHDOG_EN
        begin
            int waited;
            waited = 0;
            while (fe_tot == s_fe && waited < 6000) begin
                @(negedge clk);
                waited++;
            end
            repeat (20) @(negedge clk);
            checks++;
            if (fe_tot - s_fe !== 1 || sv_tot !== s_sv) begin
                failures++;
                $display("FAIL wd_timeout: fe=%0d sv=%0d want 1/0", fe_tot - s_fe, sv_tot - s_sv);
            end
            checks++;
            if (fe_cyc - last_fall < 5000 || fe_cyc - last_fall > 5020) begin
                failures++;
                $display("FAIL wd_latency: got %0d want 5000..5020", fe_cyc - last_fall);
            end
            m_ext = 0;
            m_brk = 0;
        end
`else
        repeat (6000) @(negedge clk);
        checks++;
        if (fe_tot !== s_fe || sv_tot !== s_sv) begin
            failures++;
            $display("FAIL wd_absent: fe=%0d sv=%0d want 0/0", fe_tot - s_fe, sv_tot - s_sv);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        model_reset();
`endif
        send_frame(8'h23, 1'b0);
        checks++;
        if (direction !== 2'b01 || scan_code !== 8'h23 || d_dv !== 1 || d_fe !== 0) begin
            failures++;
            $display("FAIL wd_recover: dir=%b code=%h dv=%0d fe=%0d want 01/23/1/0",
                     direction, scan_code, d_dv, d_fe);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         bad;
        int         r;
        for (int n = 0; n < 24; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      b = 8'hE0;
            else if (r < 3) b = 8'hF0;
            else if (r < 7) b = ($urandom_range(0, 1) != 0) ? ext_keys[$urandom_range(0, 3)]
                                                            : norm_keys[$urandom_range(0, 3)];
            else            b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, bad);
            checks++;
            if (d_sv !== int'(exp_sv) || d_dv !== int'(exp_dv) || d_fe !== int'(exp_fe) ||
                d_wide !== 0 || d_alone !== 0) begin
                failures++;
                $display("FAIL rand_pulses[%0d] byte=%h: sv=%0d dv=%0d fe=%0d wide=%0d alone=%0d want %0d/%0d/%0d/0/0",
                         n, b, d_sv, d_dv, d_fe, d_wide, d_alone, exp_sv, exp_dv, exp_fe);
            end
            checks++;
            if (direction !== m_dir) begin
                failures++;
                $display("FAIL rand_dir[%0d] byte=%h: got %b want %b", n, b, direction, m_dir);
            end
            if (exp_sv) begin
                checks++;
                if ({scan_code, is_extended, is_break} !== {m_code, exp_ext, exp_brk} ||
                    sv_cyc - last_fall !== 11) begin
                    failures++;
                    $display("FAIL rand_code[%0d]: code=%h ext=%b brk=%b lat=%0d want %h/%b/%b/11",
                             n, scan_code, is_extended, is_break, sv_cyc - last_fall,
                             m_code, exp_ext, exp_brk);
                end
            end
        end
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL global_timeout: bench exceeded cycle budget");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_make_code();
        test_extended();
        test_parity_error();
        test_glitch();
        test_reset_mid_frame();
        test_watchdog();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
